fetch_ctrl: RTL
===============

Name: fetch_ctrl

Overview:
- Instruction-fetch controller for the MIPS core. Owns the PC and drives the address of the asynchronous instruction ROM.
- Captures the returned word into a one-entry instruction register (IR) and hands it to decode over a valid/ready handshake.
- Applies branch, jump and jr redirects with a fixed one-bubble penalty. Stops cleanly at the end of ROM or on a misaligned target.

Parameters:
- address_data, 32: PC, address and instruction width.
- memory_size, 256: ROM depth in words. A fetch with word index pc[address_data-1:2] >= memory_size is out of range.
- reset_pc, 0: PC value loaded on reset and on start.

Ports:
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins fetching from IDLE.
- i_addr  out  address_data  ROM address, always equal to pc (combinational from the register).
- i_data  in  address_data  ROM instruction word, valid in the same cycle as i_addr.
- instr  out  address_data  IR contents.
- instr_pc  out  address_data  address of the instruction held in IR.
- instr_valid  out  1  IR holds a valid instruction.
- instr_ready  in  1  decode accepts IR this cycle.
- branch_taken  in  1  redirect, PC-relative.
- branch_offset  in  address_data  sign-extended word offset.
- jump  in  1  redirect, absolute.
- jump_target  in  26  word target field.
- jr  in  1  redirect, register.
- jr_addr  in  address_data  byte target.
- halted  out  1  fetch finished, IR drained.
- fault  out  1  misaligned redirect seen; sticky.
- fetch_count  out  32  number of accepted instructions.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - state=IDLE, pc=reset_pc, IR valid=0, instr=0, instr_pc=0.
  - halted=0, fault=0, fetch_count=0.
- States: IDLE, RUN, DRAIN, HALT, FAULT.
  - IDLE: no fetch. On start -> RUN with pc=reset_pc.
  - RUN: fetch on every cycle where the IR is free.
  - DRAIN: pc is out of range; no new fetch. Go to HALT once IR is empty.
  - HALT: halted=1; stays until reset.
  - FAULT: fault=1, instr_valid=0; stays until reset.
- IR free this cycle = !instr_valid OR (instr_valid AND instr_ready).
- Accept = instr_valid AND instr_ready. Redirect inputs are sampled only on accept and are ignored otherwise.
- RUN, IR free, no redirect, pc in range:
  - IR <= i_data, instr_pc <= pc, valid <= 1, pc <= pc+4.
  - Latency: address issued to instr_valid is 1 cycle.
- RUN, accept with a redirect:
  - Priority: jr > jump > branch_taken.
  - Targets:
    - branch: instr_pc + 4 + (branch_offset << 2).
    - jump: {(instr_pc+4)[31:28], jump_target, 2'b00}.
    - jr: jr_addr.
  - pc <= target and valid <= 0. The word fetched this cycle is wrong-path and is discarded. Exactly one bubble per redirect.
- Redirect target with bits [1:0] != 0 (reachable only via jr): -> FAULT on the same edge. IR is cleared and pc is left unchanged.
- Accept with no redirect while IR free and pc in range: IR reloads in the same cycle, so back-to-back throughput is 1 instruction per cycle.
- pc out of range while in RUN: -> DRAIN. An accept of the last IR entry that carries a redirect back into range returns to RUN.
- instr_valid=1 and instr_ready=0: IR, instr_pc and pc all hold. No fetch is lost.
- fetch_count increments on each accept and wraps modulo 2^32.
- Arithmetic is modulo 2^address_data. PC wrap-around is legal but lands out of range, which leads to DRAIN.
- start outside IDLE is ignored.
- Asynchronous reset mid-operation returns all state to reset values immediately, regardless of the handshake.

Test Plan:
1. Reset, start, ROM words 0..3, instr_ready=1 -> instr_valid rises 1 cycle after start+1; instr_pc=0,4,8,12 on consecutive cycles; fetch_count=4.
2. instr_ready held 0 for 3 cycles at instr_pc=8 -> instr and instr_pc hold; i_addr stays 12; on release the sequence resumes at 12 with no gaps.
3. Accept at instr_pc=0x10 with branch_taken=1, branch_offset=-2 -> one bubble (instr_valid=0), then instr_pc=0x0C. Repeat with jump=1, jump_target=0x40 -> instr_pc=0x100. Assert jr, jump and branch together, jr_addr=0x20 -> instr_pc=0x20.
4. memory_size=4, run sequentially -> after instr_pc=0x0C is accepted, halted=1, instr_valid=0, fetch_count=4; start is ignored afterwards.
5. jr=1, jr_addr=0x22 on accept -> fault=1 next cycle, instr_valid=0, i_addr stays unchanged; fault clears only on reset_n low.
6. reset_n pulsed low mid-stream with instr_valid=1 -> all outputs reach reset values without waiting for a clock edge; a new start fetches from reset_pc.

Source files
------------

// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: owns the PC, fills a one-entry IR from an asynchronous ROM and
// hands it to decode over valid/ready, applying branch/jump/jr redirects with one bubble.
module fetch_ctrl #(
  parameter int unsigned             address_data = 32,
  parameter int unsigned             memory_size  = 256,
  parameter logic [address_data-1:0] reset_pc     = '0
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    start,
  output logic [address_data-1:0] i_addr,
  input  logic [address_data-1:0] i_data,
  output logic [address_data-1:0] instr,
  output logic [address_data-1:0] instr_pc,
  output logic                    instr_valid,
  input  logic                    instr_ready,
  input  logic                    branch_taken,
  input  logic [address_data-1:0] branch_offset,
  input  logic                    jump,
  input  logic [25:0]             jump_target,
  input  logic                    jr,
  input  logic [address_data-1:0] jr_addr,
  output logic                    halted,
  output logic                    fault,
  output logic [31:0]             fetch_count
);

  localparam int unsigned AW = address_data;
  localparam logic [AW-1:0] MemWords = AW'(memory_size);
  localparam logic [AW-1:0] WordBytes = AW'(4);

  typedef enum logic [2:0] {StIdle, StRun, StDrain, StHalt, StFault} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [AW-1:0] ir_q, ir_d;
  logic [AW-1:0] ir_pc_q, ir_pc_d;
  logic          valid_q, valid_d;
  logic          halted_q, halted_d;
  logic          fault_q, fault_d;
  logic [31:0]   count_q, count_d;

  logic          accept;
  logic          ir_free;
  logic          pc_in_range;
  logic          redirect;
  logic          misaligned;
  logic [AW-1:0] seq_pc;
  logic [AW-1:0] branch_tgt;
  logic [AW-1:0] jump_tgt;
  logic [AW-1:0] redir_tgt;

  // Redirect targets are relative to the instruction being accepted, not to the fetch PC.
  always_comb begin
    accept      = valid_q & instr_ready;
    ir_free     = ~valid_q | accept;
    pc_in_range = {2'b00, pc_q[AW-1:2]} < MemWords;
    redirect    = accept & (jr | jump | branch_taken);
    seq_pc      = ir_pc_q + WordBytes;
    branch_tgt  = seq_pc + (branch_offset << 2);
    jump_tgt    = {seq_pc[AW-1:28], jump_target, 2'b00};
    if (jr) begin
      redir_tgt = jr_addr;
    end else if (jump) begin
      redir_tgt = jump_tgt;
    end else begin
      redir_tgt = branch_tgt;
    end
    misaligned = |redir_tgt[1:0];
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    ir_pc_d  = ir_pc_q;
    valid_d  = valid_q;
    halted_d = halted_q;
    fault_d  = fault_q;
    count_d  = accept ? count_q + 32'd1 : count_q;

    case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StRun;
          pc_d    = reset_pc;
        end
      end

      StRun, StDrain: begin
        if (redirect) begin
          valid_d = 1'b0;
          if (misaligned) begin
            // PC is left pointing at the fetch that was in flight.
            state_d = StFault;
            fault_d = 1'b1;
            ir_d    = '0;
            ir_pc_d = '0;
          end else begin
            state_d = StRun;
            pc_d    = redir_tgt;
          end
        end else if ((state_q == StRun) && pc_in_range) begin
          if (ir_free) begin
            ir_d    = i_data;
            ir_pc_d = pc_q;
            valid_d = 1'b1;
            pc_d    = pc_q + WordBytes;
          end
        end else begin
          if (accept) begin
            valid_d = 1'b0;
          end
          if (state_q == StRun) begin
            state_d = StDrain;
          end else if (!valid_q) begin
            state_d  = StHalt;
            halted_d = 1'b1;
          end
        end
      end

      StHalt, StFault: begin
        state_d = state_q;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      pc_q     <= reset_pc;
      ir_q     <= '0;
      ir_pc_q  <= '0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
      fault_q  <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      ir_pc_q  <= ir_pc_d;
      valid_q  <= valid_d;
      halted_q <= halted_d;
      fault_q  <= fault_d;
      count_q  <= count_d;
    end
  end

  assign i_addr      = pc_q;
  assign instr       = ir_q;
  assign instr_pc    = ir_pc_q;
  assign instr_valid = valid_q;
  assign halted      = halted_q;
  assign fault       = fault_q;
  assign fetch_count = count_q;

endmodule
